bsg_upstream_sso_tx: RTL and testbench

Parametrised source-synchronous upstream transmitter for the off-chip link.
- Accepts CORE_WIDTH-bit core words through a valid/ready handshake.
- Serialises each word over BEATS cycles across CHANNELS parallel channels of CH_WIDTH bits.
- Gates transmission with a receiver-credit counter replenished by token edges.
- Successor to the fixed 2-channel/64-bit upstream path: generalised in channel count, channel width and depth, and adds gapless back-to-back streaming, credit saturation and error reporting.

---
 rtl/bsg_sso_pkg.sv | 11 +
 rtl/bsg_sso_credit_ctr.sv | 40 ++++
 rtl/bsg_upstream_sso_tx.sv | 95 +++++++++
 tb/tb_bsg_upstream_sso_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bsg_sso_pkg.sv
// bsg_sso_pkg: shared types, calibration patterns and credit width helper for the SSO transmitter
// Optional feature macro used by the top: BSG_SSO_TX_CALIB_EN
package bsg_sso_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
  // Wide enough for any practical CH_WIDTH; callers slice the low CH_WIDTH bits.
  localparam logic [255:0] CALIB_A = {128{2'b01}};
  localparam logic [255:0] CALIB_B = {128{2'b10}};
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction
endpackage

// File: rtl/bsg_sso_credit_ctr.sv
// bsg_sso_credit_ctr: receiver-credit counter with token edge detect, saturation and sticky overflow
// Ports: clk, rst_n (async active-low), token_i (synchronised token level), consume_i (word accepted),
//        credit_o (current credits), overflow_o (sticky: return exceeded CREDITS)
module bsg_sso_credit_ctr import bsg_sso_pkg::*; #(
  parameter int CREDITS = 16,
  parameter int LG_TOKEN_DECIM = 2,
  localparam int CW = credit_width(CREDITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          token_i,
  input  logic          consume_i,
  output logic [CW-1:0] credit_o,
  output logic          overflow_o
);
  localparam int W = CW + LG_TOKEN_DECIM + 2;
  logic [CW-1:0] credit_q, credit_d;
  logic overflow_q, overflow_d, token_q, rise, over;
  logic [W-1:0] sum;
  always_comb begin
    rise = token_i & ~token_q;
    sum = W'(credit_q) + (rise ? W'(2 ** LG_TOKEN_DECIM) : W'(0)) - W'(consume_i);
    over = sum > W'(CREDITS);
    credit_d = over ? CW'(CREDITS) : sum[CW-1:0];
    overflow_d = overflow_q | over;
  end
  // token_q resets high so a token already high at reset release is not counted.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credit_q <= CW'(CREDITS);
      overflow_q <= 1'b0;
      token_q <= 1'b1;
    end else begin
      credit_q <= credit_d;
      overflow_q <= overflow_d;
      token_q <= token_i;
    end
  assign credit_o = credit_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/bsg_upstream_sso_tx.sv
// bsg_upstream_sso_tx: credit-gated source-synchronous transmitter serialising core words over CHANNELS x CH_WIDTH beats
// Ports: clk, rst_n (async active-low); core_valid_i/core_data_i/core_ready_o core handshake; token_i credit token level;
//        io_valid_o/io_data_o beat outputs; commit_o last-beat pulse; sent_cnt_o/finish_cnt_o word counters;
//        credit_o credit count; overflow_o sticky credit overflow; calib_i only when BSG_SSO_TX_CALIB_EN is defined.
module bsg_upstream_sso_tx import bsg_sso_pkg::*; #(
  parameter int CHANNELS = 2,
  parameter int CH_WIDTH = 8,
  parameter int BEATS = 4,
  parameter int CREDITS = 16,
  parameter int LG_TOKEN_DECIM = 2,
  parameter int CNT_WIDTH = 7,
  localparam int CORE_WIDTH = CHANNELS * CH_WIDTH * BEATS,
  localparam int BW = CHANNELS * CH_WIDTH,
  localparam int CW = credit_width(CREDITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_valid_i,
  input  logic [CORE_WIDTH-1:0] core_data_i,
  output logic                  core_ready_o,
  input  logic                  token_i,
`ifdef BSG_SSO_TX_CALIB_EN
  input  logic                  calib_i,
`endif
  output logic [CHANNELS-1:0]   io_valid_o,
  output logic [BW-1:0]         io_data_o,
  output logic                  commit_o,
  output logic [CNT_WIDTH-1:0]  sent_cnt_o,
  output logic [CNT_WIDTH-1:0]  finish_cnt_o,
  output logic [CW-1:0]         credit_o,
  output logic                  overflow_o
);
  localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(BEATS - 1);
  state_e state_q, state_d;
  logic [BCW-1:0] b_q, b_d;
  logic [CORE_WIDTH-1:0] word_q, word_d;
  logic [CHANNELS-1:0] io_valid_q, io_valid_d;
  logic [BW-1:0] io_data_q, io_data_d, pat;
  logic [CNT_WIDTH-1:0] sent_q, sent_d, fin_q, fin_d;
  logic phase_q, phase_d, last, acc, calib;
  logic [CW-1:0] credit;
`ifdef BSG_SSO_TX_CALIB_EN
  assign calib = calib_i & (state_q == IDLE);
`else
  assign calib = 1'b0;
`endif
  assign last = (state_q == SEND) && (b_q == LAST);
  assign core_ready_o = ((state_q == IDLE) | (b_q == LAST)) & (credit != '0) & ~calib;
  assign acc = core_valid_i & core_ready_o;
  bsg_sso_credit_ctr #(.CREDITS(CREDITS), .LG_TOKEN_DECIM(LG_TOKEN_DECIM)) u_credit (
    .clk(clk), .rst_n(rst_n), .token_i(token_i), .consume_i(acc),
    .credit_o(credit), .overflow_o(overflow_o)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      b_q <= '0;
      word_q <= '0;
      io_valid_q <= '0;
      io_data_q <= '0;
      sent_q <= '0;
      fin_q <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      word_q <= word_d;
      io_valid_q <= io_valid_d;
      io_data_q <= io_data_d;
      sent_q <= sent_d;
      fin_q <= fin_d;
      phase_q <= phase_d;
    end
  always_comb begin
    state_d = acc ? SEND : (state_q == SEND && b_q != LAST) ? SEND : IDLE;
    b_d = (state_d == SEND && !acc) ? b_q + 1'b1 : '0;
  end
  // word_q holds the not-yet-sent beats right-aligned, so the next beat is always its low slice.
  always_comb begin
    pat = phase_q ? {CHANNELS{CALIB_B[CH_WIDTH-1:0]}} : {CHANNELS{CALIB_A[CH_WIDTH-1:0]}};
    word_d = acc ? core_data_i >> BW : (state_d == SEND) ? word_q >> BW : word_q;
    io_valid_d = (state_d == SEND || calib) ? '1 : '0;
    io_data_d = acc ? core_data_i[BW-1:0] : (state_d == SEND) ? word_q[BW-1:0] : calib ? pat : '0;
    phase_d = calib & ~phase_q;
    sent_d = sent_q + CNT_WIDTH'(acc);
    fin_d = fin_q + CNT_WIDTH'(last);
  end
  assign io_valid_o = io_valid_q;
  assign io_data_o = io_data_q;
  assign commit_o = last;
  assign sent_cnt_o = sent_q;
  assign finish_cnt_o = fin_q;
  assign credit_o = credit;
endmodule

// File: tb/tb_bsg_upstream_sso_tx.sv
// tb_bsg_upstream_sso_tx: directed and random checks of the SSO transmitter against a beat-queue reference model
module tb_bsg_upstream_sso_tx;
  localparam int CHANNELS = 2, CH_WIDTH = 8, BEATS = 4, CREDITS = 16, LG = 2, CNT_WIDTH = 7;
  localparam int BW = CHANNELS * CH_WIDTH, CORE = BW * BEATS, CW = $clog2(CREDITS + 1), R = 1 << LG;
  logic clk = 1'b0, rst_n = 1'b0, core_valid_i = 1'b0, token_i = 1'b0;
  logic [CORE-1:0] core_data_i = '0;
  logic core_ready_o, commit_o, overflow_o;
  logic [CHANNELS-1:0] io_valid_o;
  logic [BW-1:0] io_data_o;
  logic [CNT_WIDTH-1:0] sent_cnt_o, finish_cnt_o;
  logic [CW-1:0] credit_o;
  bsg_upstream_sso_tx #(.CHANNELS(CHANNELS), .CH_WIDTH(CH_WIDTH), .BEATS(BEATS), .CREDITS(CREDITS),
    .LG_TOKEN_DECIM(LG), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .core_valid_i(core_valid_i), .core_data_i(core_data_i),
    .core_ready_o(core_ready_o), .token_i(token_i), .io_valid_o(io_valid_o), .io_data_o(io_data_o),
    .commit_o(commit_o), .sent_cnt_o(sent_cnt_o), .finish_cnt_o(finish_cnt_o),
    .credit_o(credit_o), .overflow_o(overflow_o)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [BW-1:0] bq[$];
  bit lq[$];
  int m_credit, m_sent, m_fin;
  bit m_prev, m_ovf;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    bq.delete();
    lq.delete();
    m_credit = CREDITS;
    m_sent = 0;
    m_fin = 0;
    m_prev = 1'b1;
    m_ovf = 1'b0;
  endtask
  function automatic bit exp_ready();
    return bq.size() <= 1 && m_credit != 0;
  endfunction
  task automatic check_outs();
    logic [CHANNELS-1:0] ev;
    ev = bq.size() > 0 ? '1 : '0;
    chk("io_valid", io_valid_o, ev);
    chk("io_data", io_data_o, bq.size() > 0 ? bq[0] : '0);
    chk("commit", commit_o, bq.size() > 0 && lq[0]);
    chk("credit", credit_o, m_credit);
    chk("sent_cnt", sent_cnt_o, m_sent % (1 << CNT_WIDTH));
    chk("finish_cnt", finish_cnt_o, m_fin % (1 << CNT_WIDTH));
    chk("overflow", overflow_o, m_ovf);
  endtask
  // One clock: drive inputs, check ready, advance model at the edge, check outputs 1 time unit later.
  task automatic cycle(input bit v, input logic [CORE-1:0] d, input bit tk);
    bit acc, rise;
    core_valid_i = v;
    core_data_i = d;
    token_i = tk;
    #1 chk("ready", core_ready_o, exp_ready());
    acc = v && exp_ready();
    @(posedge clk);
    if (bq.size() > 0) begin
      if (lq[0]) m_fin++;
      void'(bq.pop_front());
      void'(lq.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < BEATS; i++) begin
        bq.push_back(d[i*BW +: BW]);
        lq.push_back(i == BEATS - 1);
      end
      m_sent++;
    end
    rise = tk && !m_prev;
    m_prev = tk;
    m_credit = m_credit - int'(acc) + (rise ? R : 0);
    if (m_credit > CREDITS) begin
      m_credit = CREDITS;
      m_ovf = 1'b1;
    end
    #1 check_outs();
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    core_valid_i = 1'b0;
    token_i = 1'b0;
    model_reset();
    #1 check_outs();
    chk("rst_ready", core_ready_o, 1'b1);
    @(negedge clk) rst_n = 1'b1;
  endtask
  function automatic logic [CORE-1:0] rnd();
    return {$urandom, $urandom};
  endfunction
  initial begin
    int first, last, cnt;
    bit tk;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outs();
    chk("rst_credit", credit_o, 16);
    @(negedge clk) rst_n = 1'b1;
    cycle(1, 64'h0706050403020100, 0);
    chk("beat0", io_data_o, 16'h0100);
    cycle(0, '0, 0);
    chk("beat1", io_data_o, 16'h0302);
    cycle(0, '0, 0);
    chk("beat2", io_data_o, 16'h0504);
    cycle(0, '0, 0);
    chk("beat3", io_data_o, 16'h0706);
    chk("beat3_commit", commit_o, 1'b1);
    cycle(0, '0, 0);
    chk("w1_sent", sent_cnt_o, 1);
    chk("w1_fin", finish_cnt_o, 1);
    chk("w1_credit", credit_o, 15);
    chk("w1_idle", io_valid_o, 2'b00);
    do_reset();
    first = -1;
    last = -1;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      cycle(1, rnd(), 0);
      if (io_valid_o === '1) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("b2b_beats", cnt, 64);
    chk("b2b_span", last - first + 1, 64);
    chk("b2b_ready", core_ready_o, 1'b0);
    chk("b2b_credit", credit_o, 0);
    cycle(0, '0, 1);
    chk("tok_credit4", credit_o, 4);
    for (int k = 0; k < 30; k++) cycle(1, rnd(), 1);
    chk("tok_sent", sent_cnt_o, 20);
    chk("tok_fin", finish_cnt_o, 20);
    chk("tok_held_credit", credit_o, 0);
    cycle(0, '0, 0);
    cycle(0, '0, 1);
    cycle(1, rnd(), 1);
    chk("credit3", credit_o, 3);
    repeat (5) cycle(0, '0, 0);
    cycle(1, rnd(), 1);
    chk("acc_tok_credit6", credit_o, 6);
    cycle(0, '0, 0);
    cycle(0, '0, 1);
    chk("credit10", credit_o, 10);
    cycle(0, '0, 0);
    cycle(0, '0, 1);
    chk("credit14", credit_o, 14);
    chk("ovf_clear", overflow_o, 1'b0);
    cycle(0, '0, 0);
    cycle(0, '0, 1);
    chk("sat_credit", credit_o, 16);
    chk("ovf_set", overflow_o, 1'b1);
    repeat (3) cycle(0, '0, 0);
    chk("ovf_sticky", overflow_o, 1'b1);
    tk = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) tk = ~tk;
      cycle(1'($urandom_range(0, 1)), rnd(), tk);
    end
    do_reset();
    cycle(1, rnd(), 0);
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    chk("mid_valid", io_valid_o, 2'b11);
    do_reset();
    chk("mid_rst_valid", io_valid_o, 2'b00);
    repeat (6) cycle(0, '0, 0);
    chk("post_rst_sent", sent_cnt_o, 0);
    chk("post_rst_credit", credit_o, 16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
